// File: rtl/i2c_target_if.sv
// I2C target pin and byte-stream bundle: pad levels in, SDA pull-down out, rx/tx byte ports.
// Target side uses the slave modport; the bench or host side uses master.
interface i2c_target_if;
    logic       scl_in;
    logic       sda_in;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       rw;
    logic       busy;

    modport slave (
        input  scl_in, sda_in, tx_data,
        output sda_oe, rx_data, rx_valid, tx_load, rw, busy
    );

    modport master (
        output scl_in, sda_in, tx_data,
        input  sda_oe, rx_data, rx_valid, tx_load, rw, busy
    );
endinterface

// File: rtl/i2c_target.sv
// Single-address I2C target: oversampled SCL/SDA, 3 clk pin-to-event, sda_oe moves 1 clk after the event.
// No clock stretching, so rx_valid must be taken unconditionally and tx_data held ready for tx_load.
module i2c_target #(
    parameter logic [6:0] DEV_ADDR = 7'h50
) (
    input  logic        clk,
    input  logic        rst,
    i2c_target_if.slave bus
);

    typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK} state_t;

    logic [1:0] r_scl_sync, r_sda_sync;
    logic       r_scl_prev, r_sda_prev;
    logic       r_scl_rise, r_scl_fall, r_start, r_stop;

    state_t     r_state, w_state;
    logic [2:0] r_cnt, w_cnt;
    logic [6:0] r_shift, w_shift;
    logic       r_sda_oe, w_sda_oe;
    logic [7:0] r_rx_data, w_rx_data;
    logic       r_rx_pend, w_rx_pend;
    logic       r_rx_valid;
    logic       r_tx_load, w_tx_load;
    logic       r_rw, w_rw;

    // Events are registered so every event sees SDA from the same pipeline depth (r_sda_prev).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scl_sync <= 2'b11;
            r_sda_sync <= 2'b11;
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
            r_scl_rise <= 1'b0;
            r_scl_fall <= 1'b0;
            r_start    <= 1'b0;
            r_stop     <= 1'b0;
        end else begin
            r_scl_sync <= {r_scl_sync[0], bus.scl_in};
            r_sda_sync <= {r_sda_sync[0], bus.sda_in};
            r_scl_prev <= r_scl_sync[1];
            r_sda_prev <= r_sda_sync[1];
            r_scl_rise <= r_scl_sync[1] & ~r_scl_prev;
            r_scl_fall <= ~r_scl_sync[1] & r_scl_prev;
            r_start    <= r_scl_sync[1] & r_scl_prev & r_sda_prev & ~r_sda_sync[1];
            r_stop     <= r_scl_sync[1] & r_scl_prev & ~r_sda_prev & r_sda_sync[1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= 3'd0;
            r_shift    <= 7'd0;
            r_sda_oe   <= 1'b0;
            r_rx_data  <= 8'h00;
            r_rx_pend  <= 1'b0;
            r_rx_valid <= 1'b0;
            r_tx_load  <= 1'b0;
            r_rw       <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_shift    <= w_shift;
            r_sda_oe   <= w_sda_oe;
            r_rx_data  <= w_rx_data;
            r_rx_pend  <= w_rx_pend;
            r_rx_valid <= r_rx_pend;
            r_tx_load  <= w_tx_load;
            r_rw       <= w_rw;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_cnt     = r_cnt;
        w_shift   = r_shift;
        w_sda_oe  = r_sda_oe;
        w_rx_data = r_rx_data;
        w_rx_pend = 1'b0;
        w_tx_load = 1'b0;
        w_rw      = r_rw;
        if (r_start) begin
            w_state  = ADDR;
            w_cnt    = 3'd0;
            w_sda_oe = 1'b0;
        end else if (r_stop) begin
            w_state  = IDLE;
            w_sda_oe = 1'b0;
        end else begin
            case (r_state)
                ADDR, WRITE: begin
                    if (r_scl_rise) begin
                        w_shift = {r_shift[5:0], r_sda_prev};
                        w_cnt   = r_cnt + 3'd1;
                        if (r_cnt == 3'd7) begin
                            if (r_state == WRITE) begin
                                w_rx_data = {r_shift, r_sda_prev};
                                w_rx_pend = 1'b1;
                                w_state   = WRITE_ACK;
                            end else if (r_shift == DEV_ADDR) begin
                                w_rw    = r_sda_prev;
                                w_state = ADDR_ACK;
                            end else begin
                                w_state = IDLE;
                            end
                        end
                    end
                end
                // r_cnt marks whether the first fall of the ACK slot has been seen.
                ADDR_ACK, WRITE_ACK: begin
                    if (r_scl_fall) begin
                        if (r_cnt == 3'd0) begin
                            w_sda_oe = 1'b1;
                            w_cnt    = 3'd1;
                        end else begin
                            w_cnt = 3'd0;
                            if (r_state == ADDR_ACK && r_rw) begin
                                w_tx_load = 1'b1;
                                w_shift   = bus.tx_data[6:0];
                                w_sda_oe  = ~bus.tx_data[7];
                                w_state   = READ;
                            end else begin
                                w_sda_oe = 1'b0;
                                w_state  = WRITE;
                            end
                        end
                    end
                end
                READ: begin
                    if (r_scl_fall) begin
                        if (r_cnt == 3'd7) begin
                            w_cnt    = 3'd0;
                            w_sda_oe = 1'b0;
                            w_state  = READ_ACK;
                        end else begin
                            w_sda_oe = ~r_shift[6];
                            w_shift  = {r_shift[5:0], 1'b0};
                            w_cnt    = r_cnt + 3'd1;
                        end
                    end
                end
                READ_ACK: begin
                    if (r_scl_rise && r_sda_prev) begin
                        w_sda_oe = 1'b0;
                        w_state  = IDLE;
                    end else if (r_scl_fall) begin
                        w_tx_load = 1'b1;
                        w_shift   = bus.tx_data[6:0];
                        w_sda_oe  = ~bus.tx_data[7];
                        w_cnt     = 3'd0;
                        w_state   = READ;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.sda_oe   = r_sda_oe;
    assign bus.rx_data  = r_rx_data;
    assign bus.rx_valid = r_rx_valid;
    assign bus.tx_load  = r_tx_load;
    assign bus.rw       = r_rw;
    assign bus.busy     = (r_state != IDLE);

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: bit-banged controller on a wired-AND SDA line.
module tb_i2c_target;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic m_scl = 1'b1;
    logic m_sda = 1'b1;

    int n_chk = 0;
    int n_bad = 0;
    int rx_cnt = 0;
    int tl_cnt = 0;
    int oe_cnt = 0;
    logic [7:0] rx_last = 8'h00;

    i2c_target_if bus();

    assign bus.scl_in = m_scl;
    assign bus.sda_in = m_sda & ~bus.sda_oe;

    i2c_target #(.DEV_ADDR(7'h50)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.rx_valid) begin
            rx_cnt  = rx_cnt + 1;
            rx_last = bus.rx_data;
        end
        if (bus.tx_load) tl_cnt = tl_cnt + 1;
        if (bus.sda_oe)  oe_cnt = oe_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SCL period starting and ending with SCL low; returns the line level mid-high.
    task automatic sbit(input logic b, output logic line);
        m_sda = b;
        clks(5);
        m_scl = 1'b1;
        clks(5);
        line = bus.sda_in;
        clks(5);
        m_scl = 1'b0;
        clks(5);
    endtask

    task automatic start_cond;
        m_sda = 1'b1;
        clks(5);
        m_scl = 1'b1;
        clks(10);
        m_sda = 1'b0;
        clks(10);
        m_scl = 1'b0;
        clks(5);
    endtask

    task automatic stop_cond;
        m_sda = 1'b0;
        clks(5);
        m_scl = 1'b1;
        clks(10);
        m_sda = 1'b1;
        clks(10);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic acked);
        logic line;
        for (int i = 7; i >= 0; i--) sbit(b[i], line);
        sbit(1'b1, line);
        acked = ~line;
    endtask

    task automatic rd_bits(output logic [7:0] d);
        logic line;
        for (int i = 7; i >= 0; i--) begin
            sbit(1'b1, line);
            d[i] = line;
        end
    endtask

    initial begin
        logic       ack;
        logic       line;
        logic [7:0] d;
        int         rx0, tl0, oe0;

        bus.tx_data = 8'h00;
        clks(4);
        rst = 1'b0;
        clks(4);

        // reset state
        check("rst_sda_oe",   32'(bus.sda_oe),   32'h0);
        check("rst_rx_data",  32'(bus.rx_data),  32'h00);
        check("rst_rx_valid", 32'(bus.rx_valid), 32'h0);
        check("rst_tx_load",  32'(bus.tx_load),  32'h0);
        check("rst_rw",       32'(bus.rw),       32'h0);
        check("rst_busy",     32'(bus.busy),     32'h0);

        // address write
        start_cond();
        check("wr_busy_start", 32'(bus.busy), 32'h1);
        send_byte(8'hA0, ack);
        check("wr_addr_ack", 32'(ack), 32'h1);
        check("wr_rw", 32'(bus.rw), 32'h0);
        send_byte(8'hA5, ack);
        check("wr_data_ack", 32'(ack), 32'h1);
        stop_cond();
        check("wr_rx_count", 32'(rx_cnt), 32'd1);
        check("wr_rx_byte", 32'(rx_last), 32'hA5);
        check("wr_rx_hold", 32'(bus.rx_data), 32'hA5);
        check("wr_busy_stop", 32'(bus.busy), 32'h0);
        check("wr_oe_idle", 32'(bus.sda_oe), 32'h0);

        // address mismatch
        rx0 = rx_cnt;
        oe0 = oe_cnt;
        start_cond();
        send_byte(8'hA2, ack);
        check("mm_addr_nack", 32'(ack), 32'h0);
        check("mm_busy", 32'(bus.busy), 32'h0);
        send_byte(8'hFF, ack);
        stop_cond();
        check("mm_oe_never", 32'(oe_cnt - oe0), 32'd0);
        check("mm_no_rx", 32'(rx_cnt - rx0), 32'd0);

        // read with ACK then NACK
        tl0 = tl_cnt;
        bus.tx_data = 8'h3C;
        start_cond();
        send_byte(8'hA1, ack);
        check("rd_addr_ack", 32'(ack), 32'h1);
        check("rd_rw", 32'(bus.rw), 32'h1);
        rd_bits(d);
        check("rd_byte1", 32'(d), 32'h3C);
        bus.tx_data = 8'hC3;
        sbit(1'b0, line);
        rd_bits(d);
        check("rd_byte2", 32'(d), 32'hC3);
        sbit(1'b1, line);
        check("rd_busy_nack", 32'(bus.busy), 32'h0);
        check("rd_oe_nack", 32'(bus.sda_oe), 32'h0);
        stop_cond();
        check("rd_tx_loads", 32'(tl_cnt - tl0), 32'd2);

        // repeated START: write then read
        rx0 = rx_cnt;
        start_cond();
        send_byte(8'hA0, ack);
        check("rs_wr_ack", 32'(ack), 32'h1);
        send_byte(8'h12, ack);
        check("rs_rw_before", 32'(bus.rw), 32'h0);
        bus.tx_data = 8'h77;
        start_cond();
        send_byte(8'hA1, ack);
        check("rs_rd_ack", 32'(ack), 32'h1);
        check("rs_rw_after", 32'(bus.rw), 32'h1);
        rd_bits(d);
        check("rs_rd_byte", 32'(d), 32'h77);
        sbit(1'b1, line);
        stop_cond();
        check("rs_rx_count", 32'(rx_cnt - rx0), 32'd1);
        check("rs_rx_byte", 32'(rx_last), 32'h12);

        // early STOP mid-byte
        rx0 = rx_cnt;
        start_cond();
        send_byte(8'hA0, ack);
        sbit(1'b1, line);
        sbit(1'b0, line);
        sbit(1'b1, line);
        sbit(1'b1, line);
        stop_cond();
        check("es_no_rx", 32'(rx_cnt - rx0), 32'd0);
        check("es_oe", 32'(bus.sda_oe), 32'h0);
        check("es_busy", 32'(bus.busy), 32'h0);
        start_cond();
        send_byte(8'hA0, ack);
        send_byte(8'h3E, ack);
        check("es_next_ack", 32'(ack), 32'h1);
        stop_cond();
        check("es_next_rx", 32'(rx_cnt - rx0), 32'd1);
        check("es_next_byte", 32'(rx_last), 32'h3E);

        // reset during the address ACK slot
        start_cond();
        for (int i = 7; i >= 0; i--) sbit(1'(8'hA0 >> i), line);
        check("rr_oe_ack", 32'(bus.sda_oe), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("rr_oe_async", 32'(bus.sda_oe), 32'h0);
        check("rr_rx_data", 32'(bus.rx_data), 32'h00);
        check("rr_rx_valid", 32'(bus.rx_valid), 32'h0);
        check("rr_tx_load", 32'(bus.tx_load), 32'h0);
        check("rr_rw", 32'(bus.rw), 32'h0);
        check("rr_busy", 32'(bus.busy), 32'h0);
        m_sda = 1'b1;
        clks(2);
        m_scl = 1'b1;
        clks(3);
        rst = 1'b0;
        clks(5);
        rx0 = rx_cnt;
        start_cond();
        send_byte(8'hA0, ack);
        check("rr_next_addr_ack", 32'(ack), 32'h1);
        send_byte(8'h5A, ack);
        stop_cond();
        check("rr_next_rx", 32'(rx_cnt - rx0), 32'd1);
        check("rr_next_byte", 32'(rx_last), 32'h5A);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/i2c_target.md
# i2c_target

Single-address I2C target (slave) port for the opposite end of the bus from our `i2c_controller`. It oversamples the open-drain SCL/SDA lines on the system clock and detects START, repeated START and STOP. It matches a 7-bit device address, receives write bytes into a byte-wide output with a valid strobe, and serves read bytes from a byte-wide input. It sits behind the pad/open-drain buffers and in front of a register file or FIFO in the host subsystem.

## Interface
- `DEV_ADDR`, 7'h50, 7-bit address this target responds to.
- `clk`  in  1  system clock, the only clock.
- `rst`  in  1  asynchronous, active-high reset.
- `scl_in`  in  1  raw SCL pin level, asynchronous.
- `sda_in`  in  1  raw SDA pin level, asynchronous.
- `sda_oe`  out  1  1 = pull SDA low; 0 = release SDA (the pad drives 0 when this is high).
- `rx_data`  out  8  last byte received in a write transfer.
- `rx_valid`  out  1  one-cycle pulse; `rx_data` is new.
- `tx_data`  in  8  next byte to return in a read transfer.
- `tx_load`  out  1  one-cycle pulse; `tx_data` is captured in this cycle.
- `rw`  out  1  R/W bit of the current addressed transfer (1 = read).
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- **Front end**
  - `scl_in` and `sda_in` each pass through a 2-FF synchronizer plus a previous-value register. Synchronizers reset to 1.
  - Event definitions:
    - `scl_rise` / `scl_fall`: edges of the synchronized SCL.
    - START: synchronized SDA falls while SCL is high.
    - STOP: synchronized SDA rises while SCL is high.
- **Bit order and counting**
  - Bits are MSB first, sampled on `scl_rise`.
  - `sda_oe` changes only on `scl_fall`, or on START/STOP/reset.
  - A 3-bit counter counts the bits of each byte.
- **States and transitions**
  - IDLE: `sda_oe`=0. START → ADDR with counter=0. All other activity is ignored, including traffic to other addresses.
  - ADDR: shift in 8 bits.
    - On the 8th `scl_rise`, if bits[7:1]==`DEV_ADDR`, latch `rw`=bit0 and go to ADDR_ACK. Otherwise go to IDLE.
  - ADDR_ACK:
    - First `scl_fall`: `sda_oe`=1.
    - Second `scl_fall`, `rw`=0: `sda_oe`=0, go to WRITE.
    - Second `scl_fall`, `rw`=1: pulse `tx_load`, load the shift register from `tx_data`, `sda_oe`=~`tx_data[7]`, go to READ.
  - WRITE: shift in 8 bits.
    - On the 8th `scl_rise`, `rx_data`←byte, pulse `rx_valid` the next cycle, go to WRITE_ACK.
  - WRITE_ACK: first `scl_fall` sets `sda_oe`=1; second `scl_fall` sets `sda_oe`=0 and goes to WRITE.
  - READ:
    - Falls 1–7: each `scl_fall` drives the next bit with `sda_oe`=~bit.
    - 8th `scl_fall`: `sda_oe`=0, go to READ_ACK.
  - READ_ACK: sample SDA on `scl_rise`.
    - 0 (ACK): on the next `scl_fall`, pulse `tx_load`, drive the new MSB, go to READ.
    - 1 (NACK): go to IDLE with `sda_oe`=0.
- **Priority**
  - START or STOP in any state overrides any same-cycle SCL edge.
  - START from any state → ADDR, counter=0, `sda_oe`=0 (repeated START).
  - STOP from any state → IDLE, `sda_oe`=0.
  - A START/STOP mid-byte discards the partial byte; `rx_valid` does not fire.
- **Reset**
  - Assertion at any time immediately forces all outputs to reset values and the state to IDLE. SDA is released within the same cycle (async).
  - Reset values: `sda_oe`=0, `rx_data`=8'h00, `rx_valid`=0, `tx_load`=0, `rw`=0, `busy`=0.
- **Data-path rules**
  - `rx_data` holds its value until the next received byte.
  - No clock stretching: the consumer must accept `rx_valid` unconditionally, and the provider must hold `tx_data` valid whenever `tx_load` may fire.

## Timing
- Pin-to-event latency is 3 clk: 2 synchronizer stages plus 1 edge-detect stage.
- SCL high and low phases must each be ≥4 clk, and SDA setup/hold around SCL edges ≥2 clk. Behaviour outside these limits is undefined.
- `sda_oe` changes exactly 1 clk after the internal `scl_fall` event, i.e. 4 clk after the pin edge.
- `rx_valid` is high exactly 1 clk, 5 clk after the 8th SCL rising pin edge.
- `tx_load` is high exactly 1 clk and coincides with the cycle the first bit of the byte is driven.
- `busy` rises 1 clk after START is detected and falls 1 clk after STOP, NACK, or an address mismatch.

## Test plan
- **Address write:** reset, then START, addr 0x50+W, byte 0xA5, STOP → ACK (`sda_oe`=1) in both ACK slots; one `rx_valid` with `rx_data`=0xA5; `busy` low after STOP.
- **Address mismatch:** START, addr 0x51+W, 0xFF → `sda_oe` stays 0 throughout; no `rx_valid`; `busy` returns to 0 after the address byte.
- **Read with ACK then NACK:** START, 0x50+R, `tx_data`=0x3C then 0xC3, controller ACKs byte 1 and NACKs byte 2 → two `tx_load` pulses; SDA bits on the bus read 0x3C then 0xC3; state is IDLE after the NACK.
- **Repeated START:** write 0x12 to 0x50, repeated START, read from 0x50 with `tx_data`=0x77 → `rx_data`=0x12; `rw` changes 0→1 at the second address; read returns 0x77.
- **Early STOP:** STOP after 4 data bits of a write → no `rx_valid`; `sda_oe`=0; `busy`=0; the next transaction to 0x50 receives bytes normally.
- **Reset mid-operation:** assert `rst` while `sda_oe`=1 during ACK → `sda_oe` drops to 0 before the next clk edge; all outputs at reset values; the next full write succeeds.
